// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means iteration controller.
//   - kmeans_state_e : pass sequencer states
//   - IDX_W          : width of centroid index buses
//   - clog2()        : ceil(log2(v)), never less than 1 so it can size a bus
//   - Q32.32 format constants for the coordinate datapath
package kmeans_pkg;

  localparam int unsigned IDX_W       = 32;
  localparam int unsigned Q_INT_BITS  = 32;
  localparam int unsigned Q_FRAC_BITS = 32;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StAssign,
    StDivIssue,
    StDivWait,
    StDone
  } kmeans_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/kmeans_accum_bank.sv
// Per-cluster accumulators: sum_x, sum_y (mod 2^W) and point count.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   clr_i                  zero every accumulator (wins over add_i)
//   add_i, add_idx_i       add add_x_i/add_y_i into cluster add_idx_i, count += 1
//   rd_idx_i               cluster to read
//   rd_x_o, rd_y_o, rd_cnt_o  sums and count of cluster rd_idx_i
module kmeans_accum_bank
  import kmeans_pkg::*;
#(
  parameter int unsigned N_CLUSTERS = 3,
  parameter int unsigned W          = 64,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned SEL_W      = clog2(N_CLUSTERS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [SEL_W-1:0] add_idx_i,
  input  logic [W-1:0]     add_x_i,
  input  logic [W-1:0]     add_y_i,
  input  logic [SEL_W-1:0] rd_idx_i,
  output logic [W-1:0]     rd_x_o,
  output logic [W-1:0]     rd_y_o,
  output logic [CNT_W-1:0] rd_cnt_o
);

  logic [W-1:0]     sum_x_q [N_CLUSTERS];
  logic [W-1:0]     sum_x_d [N_CLUSTERS];
  logic [W-1:0]     sum_y_q [N_CLUSTERS];
  logic [W-1:0]     sum_y_d [N_CLUSTERS];
  logic [CNT_W-1:0] cnt_q   [N_CLUSTERS];
  logic [CNT_W-1:0] cnt_d   [N_CLUSTERS];

  // Index decode by comparison so a non-power-of-two K never indexes past the array.
  always_comb begin
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    cnt_d   = cnt_q;
    for (int c = 0; c < N_CLUSTERS; c++) begin
      if (clr_i) begin
        sum_x_d[c] = '0;
        sum_y_d[c] = '0;
        cnt_d[c]   = '0;
      end else if (add_i && (add_idx_i == SEL_W'(c))) begin
        sum_x_d[c] = sum_x_q[c] + add_x_i;
        sum_y_d[c] = sum_y_q[c] + add_y_i;
        cnt_d[c]   = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_x_o   = '0;
    rd_y_o   = '0;
    rd_cnt_o = '0;
    for (int c = 0; c < N_CLUSTERS; c++) begin
      if (rd_idx_i == SEL_W'(c)) begin
        rd_x_o   = sum_x_q[c];
        rd_y_o   = sum_y_q[c];
        rd_cnt_o = cnt_q[c];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < N_CLUSTERS; c++) begin
        sum_x_q[c] <= '0;
        sum_y_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/kmeans_iter_ctrl.sv
// Sequences one k-means update pass: stream N_POINTS points through the external
// assignment datapath, accumulate per-cluster sums/counts, divide each non-empty
// cluster through the shared divider and write the new centroids back.
// Ports: clk/reset_n; io_start/io_busy/io_done/io_err host control; io_pt_* point
// stream; io_asg_* assignment datapath; io_div_* divider; io_cent_* centroid store
// writes; io_empty_mask clusters with no points this pass.
// Optional feature, macro KMEANS_CHANGE_CNT_EN: per-point previous-assignment RAM
// and the io_changed output (points whose assignment moved since the last pass).
module kmeans_iter_ctrl
  import kmeans_pkg::*;
#(
  parameter int unsigned N_CLUSTERS = 3,
  parameter int unsigned N_POINTS   = 10,
  parameter int unsigned W          = 64,
  parameter int unsigned CNT_W      = clog2(N_POINTS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  io_start,
  output logic                  io_busy,
  output logic                  io_done,
  output logic                  io_err,
  input  logic                  io_pt_valid,
  output logic                  io_pt_ready,
  input  logic [W-1:0]          io_pt_x,
  input  logic [W-1:0]          io_pt_y,
  output logic                  io_asg_req_valid,
  input  logic                  io_asg_req_ready,
  output logic [W-1:0]          io_asg_x,
  output logic [W-1:0]          io_asg_y,
  input  logic                  io_asg_rsp_valid,
  input  logic [IDX_W-1:0]      io_asg_rsp_idx,
  output logic                  io_div_req_valid,
  input  logic                  io_div_req_ready,
  output logic [W-1:0]          io_div_num_x,
  output logic [W-1:0]          io_div_num_y,
  output logic [W-1:0]          io_div_den,
  input  logic                  io_div_rsp_valid,
  input  logic [W-1:0]          io_div_rsp_x,
  input  logic [W-1:0]          io_div_rsp_y,
  output logic                  io_cent_we,
  output logic [IDX_W-1:0]      io_cent_idx,
  output logic [W-1:0]          io_cent_x,
  output logic [W-1:0]          io_cent_y,
`ifdef KMEANS_CHANGE_CNT_EN
  output logic [CNT_W-1:0]      io_changed,
`endif
  output logic [N_CLUSTERS-1:0] io_empty_mask
);

  localparam int unsigned SEL_W = clog2(N_CLUSTERS);
  localparam logic [SEL_W-1:0] LastC = SEL_W'(N_CLUSTERS - 1);
  localparam logic [CNT_W-1:0] LastP = CNT_W'(N_POINTS - 1);

  kmeans_state_e         state_q, state_d;
  logic [W-1:0]          pt_x_q, pt_x_d, pt_y_q, pt_y_d;
  logic                  sent_q, sent_d;  // assignment request accepted, awaiting rsp
  logic [CNT_W-1:0]      pcnt_q, pcnt_d;
  logic [SEL_W-1:0]      c_q, c_d;
  logic                  err_q, err_d;
  logic [N_CLUSTERS-1:0] empty_q, empty_d;

  logic             acc_clr, acc_add;
  logic [W-1:0]     rd_x, rd_y;
  logic [CNT_W-1:0] rd_cnt;
  logic             idx_ok, asg_rsp_fire;

  assign idx_ok       = io_asg_rsp_idx < IDX_W'(N_CLUSTERS);
  // Responses only count while a request is outstanding; anything else is stray.
  assign asg_rsp_fire = (state_q == StAssign) && sent_q && io_asg_rsp_valid;

  assign io_busy       = (state_q != StIdle);
  assign io_err        = err_q;
  assign io_empty_mask = empty_q;

  kmeans_accum_bank #(
    .N_CLUSTERS(N_CLUSTERS),
    .W         (W),
    .CNT_W     (CNT_W),
    .SEL_W     (SEL_W)
  ) u_accum (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .clr_i    (acc_clr),
    .add_i    (acc_add),
    .add_idx_i(io_asg_rsp_idx[SEL_W-1:0]),
    .add_x_i  (pt_x_q),
    .add_y_i  (pt_y_q),
    .rd_idx_i (c_q),
    .rd_x_o   (rd_x),
    .rd_y_o   (rd_y),
    .rd_cnt_o (rd_cnt)
  );

  always_comb begin
    state_d          = state_q;
    pt_x_d           = pt_x_q;
    pt_y_d           = pt_y_q;
    sent_d           = sent_q;
    pcnt_d           = pcnt_q;
    c_d              = c_q;
    err_d            = err_q;
    empty_d          = empty_q;
    acc_clr          = 1'b0;
    acc_add          = 1'b0;
    io_done          = 1'b0;
    io_pt_ready      = 1'b0;
    io_asg_req_valid = 1'b0;
    io_asg_x         = '0;
    io_asg_y         = '0;
    io_div_req_valid = 1'b0;
    io_div_num_x     = '0;
    io_div_num_y     = '0;
    io_div_den       = '0;
    io_cent_we       = 1'b0;
    io_cent_idx      = '0;
    io_cent_x        = '0;
    io_cent_y        = '0;
    unique case (state_q)
      StIdle: begin
        if (io_start) state_d = StClear;
      end
      StClear: begin
        acc_clr = 1'b1;
        err_d   = 1'b0;
        empty_d = '0;
        pcnt_d  = '0;
        state_d = StFeed;
      end
      StFeed: begin
        io_pt_ready = 1'b1;
        if (io_pt_valid) begin
          pt_x_d  = io_pt_x;
          pt_y_d  = io_pt_y;
          sent_d  = 1'b0;
          state_d = StAssign;
        end
      end
      StAssign: begin
        if (!sent_q) begin
          io_asg_req_valid = 1'b1;
          io_asg_x         = pt_x_q;
          io_asg_y         = pt_y_q;
          if (io_asg_req_ready) sent_d = 1'b1;
        end else if (asg_rsp_fire) begin
          acc_add = idx_ok;
          if (!idx_ok) err_d = 1'b1;
          pcnt_d = pcnt_q + CNT_W'(1);
          if (pcnt_q == LastP) begin
            c_d     = '0;
            state_d = StDivIssue;
          end else begin
            state_d = StFeed;
          end
        end
      end
      StDivIssue: begin
        if (rd_cnt == '0) begin
          for (int c = 0; c < N_CLUSTERS; c++) begin
            if (c_q == SEL_W'(c)) empty_d[c] = 1'b1;
          end
          if (c_q == LastC) state_d = StDone;
          else c_d = c_q + SEL_W'(1);
        end else begin
          io_div_req_valid = 1'b1;
          io_div_num_x     = rd_x;
          io_div_num_y     = rd_y;
          io_div_den       = W'(rd_cnt);
          if (io_div_req_ready) state_d = StDivWait;
        end
      end
      StDivWait: begin
        if (io_div_rsp_valid) begin
          io_cent_we  = 1'b1;
          io_cent_idx = IDX_W'(c_q);
          io_cent_x   = io_div_rsp_x;
          io_cent_y   = io_div_rsp_y;
          if (c_q == LastC) begin
            state_d = StDone;
          end else begin
            c_d     = c_q + SEL_W'(1);
            state_d = StDivIssue;
          end
        end
      end
      StDone: begin
        io_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pt_x_q  <= '0;
      pt_y_q  <= '0;
      sent_q  <= 1'b0;
      pcnt_q  <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      empty_q <= '0;
    end else begin
      state_q <= state_d;
      pt_x_q  <= pt_x_d;
      pt_y_q  <= pt_y_d;
      sent_q  <= sent_d;
      pcnt_q  <= pcnt_d;
      c_q     <= c_d;
      err_q   <= err_d;
      empty_q <= empty_d;
    end
  end

`ifdef KMEANS_CHANGE_CNT_EN
  logic [SEL_W-1:0]    prev_q [N_POINTS];
  logic [SEL_W-1:0]    prev_d [N_POINTS];
  logic [N_POINTS-1:0] prev_vld_q, prev_vld_d;
  logic [CNT_W-1:0]    changed_q, changed_d;

  assign io_changed = changed_q;

  // A point with no recorded assignment or a dropped index always counts as moved.
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    changed_d  = changed_q;
    if (state_q == StClear) changed_d = '0;
    if (asg_rsp_fire) begin
      for (int p = 0; p < N_POINTS; p++) begin
        if (pcnt_q == CNT_W'(p)) begin
          if (!idx_ok || !prev_vld_q[p] || (prev_q[p] != io_asg_rsp_idx[SEL_W-1:0])) begin
            changed_d = changed_q + CNT_W'(1);
          end
          if (idx_ok) begin
            prev_d[p]     = io_asg_rsp_idx[SEL_W-1:0];
            prev_vld_d[p] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < N_POINTS; p++) prev_q[p] <= '0;
      prev_vld_q <= '0;
      changed_q  <= '0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      changed_q  <= changed_d;
    end
  end
`endif

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Randomized bench for kmeans_iter_ctrl. Expected sums, division requests, centroid
// writes, empty mask, error flag and change count are computed per pass from the
// point list; peers are modelled with random stalls and stray response strobes.
module tb_kmeans_iter_ctrl;
  localparam int K = 3;
  localparam int NP = 10;
  localparam int W = 64;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic io_start = 1'b0, io_busy, io_done, io_err;
  logic io_pt_valid = 1'b0, io_pt_ready;
  logic [W-1:0] io_pt_x = '0, io_pt_y = '0;
  logic io_asg_req_valid, io_asg_req_ready = 1'b0;
  logic [W-1:0] io_asg_x, io_asg_y;
  logic io_asg_rsp_valid = 1'b0;
  logic [31:0] io_asg_rsp_idx = '0;
  logic io_div_req_valid, io_div_req_ready = 1'b0;
  logic [W-1:0] io_div_num_x, io_div_num_y, io_div_den;
  logic io_div_rsp_valid = 1'b0;
  logic [W-1:0] io_div_rsp_x = '0, io_div_rsp_y = '0;
  logic io_cent_we;
  logic [31:0] io_cent_idx;
  logic [W-1:0] io_cent_x, io_cent_y;
  logic [K-1:0] io_empty_mask;
`ifdef KMEANS_CHANGE_CNT_EN
  logic [CNT_W-1:0] io_changed;
`endif

  kmeans_iter_ctrl dut (
    .clk(clk), .reset_n(reset_n), .io_start(io_start), .io_busy(io_busy),
    .io_done(io_done), .io_err(io_err), .io_pt_valid(io_pt_valid),
    .io_pt_ready(io_pt_ready), .io_pt_x(io_pt_x), .io_pt_y(io_pt_y),
    .io_asg_req_valid(io_asg_req_valid), .io_asg_req_ready(io_asg_req_ready),
    .io_asg_x(io_asg_x), .io_asg_y(io_asg_y), .io_asg_rsp_valid(io_asg_rsp_valid),
    .io_asg_rsp_idx(io_asg_rsp_idx), .io_div_req_valid(io_div_req_valid),
    .io_div_req_ready(io_div_req_ready), .io_div_num_x(io_div_num_x),
    .io_div_num_y(io_div_num_y), .io_div_den(io_div_den),
    .io_div_rsp_valid(io_div_rsp_valid), .io_div_rsp_x(io_div_rsp_x),
    .io_div_rsp_y(io_div_rsp_y), .io_cent_we(io_cent_we), .io_cent_idx(io_cent_idx),
    .io_cent_x(io_cent_x), .io_cent_y(io_cent_y),
`ifdef KMEANS_CHANGE_CNT_EN
    .io_changed(io_changed),
`endif
    .io_empty_mask(io_empty_mask)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [W-1:0] pts_x[NP], pts_y[NP];
  int unsigned pts_i[NP];
  // Previous-pass assignments, for the change-count model.
  int unsigned prev_i[NP];
  bit prev_v[NP];

  // What the DUT showed during the last pass, for the literal checks.
  int obs_den[$];
  int obs_wr[$];
  logic [K-1:0] obs_mask;
  logic obs_err;
  int obs_gap;
  int obs_changed;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic any_out();
    return |{io_busy, io_done, io_err, io_pt_ready, io_asg_req_valid, io_asg_x, io_asg_y,
             io_div_req_valid, io_div_num_x, io_div_num_y, io_div_den, io_cent_we,
             io_cent_idx, io_cent_x, io_cent_y, io_empty_mask
`ifdef KMEANS_CHANGE_CNT_EN
             , io_changed
`endif
             };
  endfunction

  task automatic idle_inputs();
    io_start = 0; io_pt_valid = 0; io_asg_req_ready = 0; io_asg_rsp_valid = 0;
    io_div_req_ready = 0; io_div_rsp_valid = 0;
  endtask

  task automatic run_pass(input bit stall, input bit stray, input int abort_at);
    logic [W-1:0] esx[K], esy[K], dqx[K], dqy[K];
    int ecnt[K], dc[K];
    int ndiv, fed, ahs, rsp_n, dhs, wr_k, last_wr, adly, ddly, echg;
    bit aout, dout, done_seen, aborted, a_hold, d_hold;
    logic [W-1:0] hax, hay, hdx, hdy, hdd;
    logic [K-1:0] emask;
    bit eerr;
    // Reference: plain accumulation over the point list.
    for (int c = 0; c < K; c++) begin esx[c] = 0; esy[c] = 0; ecnt[c] = 0; end
    eerr = 0; echg = 0;
    for (int p = 0; p < NP; p++) begin
      if (pts_i[p] < K) begin
        esx[pts_i[p]] += pts_x[p]; esy[pts_i[p]] += pts_y[p]; ecnt[pts_i[p]]++;
        if (!prev_v[p] || prev_i[p] != pts_i[p]) echg++;
      end else begin
        eerr = 1; echg++;
      end
    end
    ndiv = 0; emask = '0;
    for (int c = 0; c < K; c++) begin
      if (ecnt[c] == 0) emask[c] = 1'b1;
      else begin
        dc[ndiv] = c;
        dqx[ndiv] = $signed(esx[c]) / longint'(ecnt[c]);
        dqy[ndiv] = $signed(esy[c]) / longint'(ecnt[c]);
        ndiv++;
      end
    end
    obs_den.delete(); obs_wr.delete();
    fed = 0; ahs = 0; rsp_n = 0; dhs = 0; wr_k = 0; last_wr = -10; adly = 0; ddly = 0;
    aout = 0; dout = 0; done_seen = 0; aborted = 0; a_hold = 0; d_hold = 0;
    hax = 0; hay = 0; hdx = 0; hdy = 0; hdd = 0;
    for (int cyc = 0; cyc < 3000 && !done_seen && !aborted; cyc++) begin
      @(negedge clk);
      io_start = (cyc == 0) || (stray && $urandom_range(3) == 0);
      if (fed < NP && (!stall || $urandom_range(2) != 0)) begin
        io_pt_valid = 1; io_pt_x = pts_x[fed]; io_pt_y = pts_y[fed];
      end else begin
        io_pt_valid = 0; io_pt_x = {$urandom, $urandom}; io_pt_y = {$urandom, $urandom};
      end
      io_asg_req_ready = stall ? ($urandom_range(1) == 1) : 1'b1;
      io_div_req_ready = stall ? ($urandom_range(1) == 1) : 1'b1;
      if (aout && adly == 0) begin
        io_asg_rsp_valid = 1; io_asg_rsp_idx = pts_i[rsp_n];
      end else begin
        if (aout) adly--;
        io_asg_rsp_valid = !aout && stray && ($urandom_range(3) == 0);
        io_asg_rsp_idx = $urandom_range(7);
      end
      if (dout && ddly == 0) begin
        io_div_rsp_valid = 1; io_div_rsp_x = dqx[dhs-1]; io_div_rsp_y = dqy[dhs-1];
      end else begin
        if (dout) ddly--;
        io_div_rsp_valid = !dout && stray && ($urandom_range(3) == 0);
        io_div_rsp_x = {$urandom, $urandom}; io_div_rsp_y = {$urandom, $urandom};
      end
      #1;
      check("busy", io_busy, cyc != 0);
      if (io_pt_valid && io_pt_ready) fed++;
      if (aout && io_asg_rsp_valid) begin aout = 0; rsp_n++; end
      if (io_asg_req_valid) begin
        if (a_hold) begin
          check("asg_x_stable", io_asg_x, hax); check("asg_y_stable", io_asg_y, hay);
        end
        check("asg_x", io_asg_x, (ahs < NP) ? pts_x[ahs] : 64'hx);
        check("asg_y", io_asg_y, (ahs < NP) ? pts_y[ahs] : 64'hx);
        hax = io_asg_x; hay = io_asg_y;
        a_hold = !io_asg_req_ready;
        if (io_asg_req_ready) begin
          ahs++; aout = 1; adly = stall ? $urandom_range(7) : 0;
        end
      end else if (a_hold) begin
        check("asg_valid_held", 0, 1); a_hold = 0;
      end
      if (dout && io_div_rsp_valid) dout = 0;
      if (io_div_req_valid) begin
        if (d_hold) begin
          check("div_x_stable", io_div_num_x, hdx); check("div_y_stable", io_div_num_y, hdy);
          check("div_den_stable", io_div_den, hdd);
        end
        if (dhs < ndiv) begin
          check("div_num_x", io_div_num_x, esx[dc[dhs]]);
          check("div_num_y", io_div_num_y, esy[dc[dhs]]);
          check("div_den", io_div_den, 64'(ecnt[dc[dhs]]));
        end else check("div_extra_req", dhs, ndiv - 1);
        hdx = io_div_num_x; hdy = io_div_num_y; hdd = io_div_den;
        d_hold = !io_div_req_ready;
        if (io_div_req_ready) begin
          obs_den.push_back(int'(io_div_den));
          dhs++; dout = 1; ddly = stall ? $urandom_range(7) : 0;
        end
      end else if (d_hold) begin
        check("div_valid_held", 0, 1); d_hold = 0;
      end
      if (io_cent_we) begin
        if (wr_k < ndiv) begin
          check("cent_idx", io_cent_idx, 64'(dc[wr_k]));
          check("cent_x", io_cent_x, dqx[wr_k]);
          check("cent_y", io_cent_y, dqy[wr_k]);
        end else check("cent_extra_write", wr_k, ndiv - 1);
        obs_wr.push_back(int'(io_cent_idx));
        wr_k++; last_wr = cyc;
      end
      if (io_done) begin
        done_seen = 1;
        check("done_points", rsp_n, NP);
        check("done_writes", wr_k, ndiv);
        check("done_mask", io_empty_mask, emask);
        check("done_err", io_err, eerr);
        obs_mask = io_empty_mask; obs_err = io_err; obs_gap = cyc - last_wr;
`ifdef KMEANS_CHANGE_CNT_EN
        check("done_changed", io_changed, echg);
        obs_changed = int'(io_changed);
`endif
      end
      if (abort_at >= 0 && ahs == abort_at && !done_seen) begin
        #1 reset_n = 0;
        #1 check("rst_outputs_zero", any_out(), 0);
        idle_inputs();
        repeat (2) @(negedge clk);
        #1 check("rst_outputs_zero_held", any_out(), 0);
        reset_n = 1;
        for (int p = 0; p < NP; p++) prev_v[p] = 0;
        aborted = 1;
      end
    end
    if (!aborted) begin
      if (!done_seen) check("done_timeout", 0, 1);
      @(negedge clk);
      idle_inputs();
      #1;
      check("idle_busy", io_busy, 0);
      check("idle_done", io_done, 0);
      check("idle_mask_hold", io_empty_mask, emask);
      check("idle_err_hold", io_err, eerr);
      for (int p = 0; p < NP; p++) if (pts_i[p] < K) begin prev_i[p] = pts_i[p]; prev_v[p] = 1; end
    end
  endtask

  task automatic rand_points(input int bad_rate);
    for (int p = 0; p < NP; p++) begin
      pts_x[p] = {$urandom, $urandom}; pts_y[p] = {$urandom, $urandom};
      pts_i[p] = (bad_rate > 0 && $urandom_range(bad_rate - 1) == 0) ? $urandom_range(31, 3)
                                                                  : $urandom_range(2);
    end
  endtask

  initial begin
    int dsum;
    for (int p = 0; p < NP; p++) prev_v[p] = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1 check("reset_outputs_zero", any_out(), 0);
    reset_n = 1;

    // Round-robin assignment, zero-latency peers.
    rand_points(0);
    for (int p = 0; p < NP; p++) pts_i[p] = p % 3;
    run_pass(0, 0, -1);
    check("rr_div_count", obs_den.size(), 3);
    if (obs_den.size() == 3) begin
      check("rr_den0", obs_den[0], 4); check("rr_den1", obs_den[1], 3);
      check("rr_den2", obs_den[2], 3);
    end
    check("rr_done_gap", obs_gap, 1);
    check("rr_write_count", obs_wr.size(), 3);
`ifdef KMEANS_CHANGE_CNT_EN
    check("chg_first_pass", obs_changed, 10);
    run_pass(0, 0, -1);
    check("chg_same_pass", obs_changed, 0);
    pts_i[2] = 0; pts_i[7] = 2;
    run_pass(0, 0, -1);
    check("chg_two_flipped", obs_changed, 2);
`endif

    // Every point to cluster 1.
    for (int p = 0; p < NP; p++) pts_i[p] = 1;
    run_pass(0, 0, -1);
    check("one_mask", obs_mask, 3'b101);
    check("one_div_count", obs_den.size(), 1);
    if (obs_den.size() == 1) check("one_den", obs_den[0], 10);
    check("one_write_count", obs_wr.size(), 1);
    if (obs_wr.size() == 1) check("one_write_idx", obs_wr[0], 1);

    // One out-of-range index.
    rand_points(0);
    pts_i[4] = 5;
    run_pass(0, 0, -1);
    check("bad_err", obs_err, 1);
    dsum = 0;
    foreach (obs_den[i]) dsum += obs_den[i];
    check("bad_total_cnt", dsum, 9);

    // Reset in the middle of a pass, then a clean pass.
    rand_points(0);
    run_pass(1, 1, 4);
    rand_points(0);
    run_pass(0, 0, -1);
    check("post_rst_err", obs_err, 0);

    // Random stalls, stray strobes, occasional bad indices.
    for (int t = 0; t < 8; t++) begin
      rand_points(12);
      run_pass(1, 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
